// File: rtl/cpu_seq_ctrl_pkg.sv
// rtl/cpu_seq_ctrl_pkg.sv - opcodes, state encoding and register names for the sequencer
package cpu_seq_ctrl_pkg;

   localparam logic [3:0] OP_LI    = 4'd0;
   localparam logic [3:0] OP_ADD   = 4'd1;
   localparam logic [3:0] OP_INC   = 4'd2;
   localparam logic [3:0] OP_COMP  = 4'd3;
   localparam logic [3:0] OP_LOAD  = 4'd4;
   localparam logic [3:0] OP_STORE = 4'd5;
   localparam logic [3:0] OP_JNZ   = 4'd6;
   localparam logic [3:0] OP_HALT  = 4'd15;

   localparam logic [2:0] S_IDLE   = 3'd0;
   localparam logic [2:0] S_FETCH  = 3'd1;
   localparam logic [2:0] S_DECODE = 3'd2;
   localparam logic [2:0] S_EXEC   = 3'd3;
   localparam logic [2:0] S_MEM    = 3'd4;
   localparam logic [2:0] S_WB     = 3'd5;
   localparam logic [2:0] S_HALT   = 3'd6;

   localparam logic [1:0] WB_ALU  = 2'd0;
   localparam logic [1:0] WB_IMM  = 2'd1;
   localparam logic [1:0] WB_DMEM = 2'd2;

   // Where DECODE sends the instruction next.
   typedef enum logic [2:0] {CLS_NOP, CLS_WB, CLS_EXEC, CLS_MEM, CLS_JNZ, CLS_HALT} cls_e;

   typedef enum logic [3:0] {R0, R1, R2, R3, R4, R5, R6, R7,
                             R8, R9, R10, R11, R12, R13, R14, R15} reg_e;

   function automatic logic [15:0] enc(input logic [3:0] opc, input logic [3:0] f2,
                                       input logic [3:0] f1, input logic [3:0] f0);
      return {opc, f2, f1, f0};
   endfunction

endpackage

// File: rtl/seq_decode.sv
// rtl/seq_decode.sv - combinational map from the instruction register to selects and flow class
module seq_decode
   import cpu_seq_ctrl_pkg::*;
#(
   parameter int OP_W = 16
) (
   input  logic [OP_W-1:0] ir,
   output logic [3:0]      rf_wsel,
   output logic [3:0]      rf_asel,
   output logic [3:0]      rf_bsel,
   output logic [1:0]      wb_sel,
   output cls_e            cls
);

   logic [3:0] opc, f2, f1, f0;

   assign opc = ir[OP_W-1 -: 4];
   assign f2  = ir[11:8];
   assign f1  = ir[7:4];
   assign f0  = ir[3:0];

   always_comb begin
      rf_wsel = '0;
      rf_asel = '0;
      rf_bsel = '0;
      wb_sel  = WB_ALU;
      cls     = CLS_NOP;
      case (opc)
         OP_LI:    begin rf_wsel = f2; wb_sel = WB_IMM; cls = CLS_WB; end
         OP_ADD:   begin rf_wsel = f2; rf_asel = f1; rf_bsel = f0; cls = CLS_EXEC; end
         OP_INC:   begin rf_wsel = f0; rf_asel = f0; cls = CLS_EXEC; end
         OP_COMP:  begin rf_asel = f1; rf_bsel = f0; cls = CLS_EXEC; end
         OP_LOAD:  begin rf_wsel = f2; rf_asel = f1; wb_sel = WB_DMEM; cls = CLS_MEM; end
         OP_STORE: begin rf_asel = f1; rf_bsel = f0; cls = CLS_MEM; end
         OP_JNZ:   cls = CLS_JNZ;
         OP_HALT:  cls = CLS_HALT;
         default:  cls = CLS_NOP;
      endcase
   end

endmodule

// File: rtl/cpu_seq_ctrl.sv
// rtl/cpu_seq_ctrl.sv - multi-cycle FETCH/DECODE/EXEC/MEM/WB sequencer owning pc, ir and the zero flag
module cpu_seq_ctrl
   import cpu_seq_ctrl_pkg::*;
#(
   parameter int PC_W = 6,
   parameter int OP_W = 16
) (
   input  logic            clk,
   input  logic            rst,
   input  logic            run,
   input  logic            halt_req,
   input  logic [OP_W-1:0] op,
   input  logic            zero_in,
   output logic [PC_W-1:0] pc,
   output logic [OP_W-1:0] ir,
   output logic            rf_we,
   output logic [3:0]      rf_wsel,
   output logic [3:0]      rf_asel,
   output logic [3:0]      rf_bsel,
   output logic [1:0]      wb_sel,
   output logic [7:0]      imm,
   output logic [3:0]      alu_fn,
   output logic            dm_we,
   output logic            dm_re,
   output logic            busy,
   output logic            halted
);

   logic [2:0]      state, state_nxt;
   logic            z;
   logic            pc_ld, boundary;
   logic [PC_W-1:0] pc_nxt;
   logic [3:0]      opc;
   cls_e            cls;

   assign opc = ir[OP_W-1 -: 4];

   seq_decode #(.OP_W(OP_W)) u_decode (
      .ir      (ir),
      .rf_wsel (rf_wsel),
      .rf_asel (rf_asel),
      .rf_bsel (rf_bsel),
      .wb_sel  (wb_sel),
      .cls     (cls)
   );

   always_comb begin
      state_nxt = state;
      pc_ld     = 1'b0;
      boundary  = 1'b0;
      pc_nxt    = pc + PC_W'(1);
      case (state)
         S_IDLE:   if (run) state_nxt = S_FETCH;
         S_FETCH:  state_nxt = S_DECODE;
         S_DECODE:
            case (cls)
               CLS_WB:   state_nxt = S_WB;
               CLS_EXEC: state_nxt = S_EXEC;
               CLS_MEM:  state_nxt = S_MEM;
               CLS_JNZ: begin
                  pc_ld    = 1'b1;
                  boundary = 1'b1;
                  if (!z) pc_nxt = ir[PC_W-1:0];
               end
               CLS_HALT: state_nxt = S_HALT;
               default: begin
                  pc_ld    = 1'b1;
                  boundary = 1'b1;
               end
            endcase
         S_EXEC:
            if (opc == OP_COMP) begin
               pc_ld    = 1'b1;
               boundary = 1'b1;
            end else begin
               state_nxt = S_WB;
            end
         S_MEM:
            if (opc == OP_LOAD) begin
               state_nxt = S_WB;
            end else begin
               pc_ld    = 1'b1;
               boundary = 1'b1;
            end
         S_WB: begin
            pc_ld    = 1'b1;
            boundary = 1'b1;
         end
         S_HALT:   if (run && !halt_req) state_nxt = S_FETCH;
         default:  state_nxt = S_IDLE;
      endcase
      // Every return to FETCH is an instruction boundary where a halt request is honoured.
      if (boundary) state_nxt = halt_req ? S_HALT : S_FETCH;
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state <= S_IDLE;
         pc    <= '0;
         ir    <= '0;
         z     <= 1'b0;
      end else begin
         state <= state_nxt;
         if (state == S_FETCH) ir <= op;
         if (state == S_EXEC && opc == OP_COMP) z <= zero_in;
         if (pc_ld) pc <= pc_nxt;
      end
   end

   // Strobes are masked by reset so a write already in flight is never issued.
   assign rf_we  = (state == S_WB) && !rst;
   assign dm_re  = (state == S_MEM) && (opc == OP_LOAD) && !rst;
   assign dm_we  = (state == S_MEM) && (opc == OP_STORE) && !rst;
   assign alu_fn = opc;
   assign imm    = ir[7:0];
   assign busy   = (state != S_IDLE) && (state != S_HALT);
   assign halted = (state == S_HALT);

endmodule

// File: tb/tb_cpu_seq_ctrl.sv
// tb/tb_cpu_seq_ctrl.sv - self-checking bench for cpu_seq_ctrl
module tb_cpu_seq_ctrl;
   import cpu_seq_ctrl_pkg::*;

   logic        clk = 1'b0;
   logic        rst, run, halt_req, zero_in;
   logic [15:0] op;
   logic [5:0]  pc;
   logic [15:0] ir;
   logic        rf_we, dm_we, dm_re, busy, halted;
   logic [3:0]  rf_wsel, rf_asel, rf_bsel, alu_fn;
   logic [1:0]  wb_sel;
   logic [7:0]  imm;

   logic [15:0] imem [64];
   assign op = imem[pc];

   always #5 clk = ~clk;

   cpu_seq_ctrl dut (
      .clk(clk), .rst(rst), .run(run), .halt_req(halt_req), .op(op), .zero_in(zero_in),
      .pc(pc), .ir(ir), .rf_we(rf_we), .rf_wsel(rf_wsel), .rf_asel(rf_asel), .rf_bsel(rf_bsel),
      .wb_sel(wb_sel), .imm(imm), .alu_fn(alu_fn), .dm_we(dm_we), .dm_re(dm_re),
      .busy(busy), .halted(halted)
   );

   int checks = 0;
   int errors = 0;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0d expected %0d", name, act, exp);
      end
   endtask

   task automatic chk_opt(input string name, input logic [31:0] act, input int exp);
      if (exp >= 0) chk(name, act, exp);
   endtask

   typedef struct {
      logic [15:0] op;
      int pc0; bit zin; int cyc; int npc;
      int nrf; int ndmw; int ndmr;
      int wb; int ws; int as_e; int bs;
   } vec_t;

   vec_t vt [12];

   // Spec-defined fields only; -1 marks a select the instruction does not use.
   function automatic void exp_dec(input logic [15:0] o, output int w, output int a,
                                   output int b, output int wb);
      w = -1; a = -1; b = -1; wb = -1;
      case (o[15:12])
         4'd0: begin w = int'(o[11:8]); wb = 1; end
         4'd1: begin w = int'(o[11:8]); a = int'(o[7:4]); b = int'(o[3:0]); wb = 0; end
         4'd2: begin w = int'(o[3:0]); a = int'(o[3:0]); wb = 0; end
         4'd3: begin a = int'(o[7:4]); b = int'(o[3:0]); end
         4'd4: begin w = int'(o[11:8]); a = int'(o[7:4]); wb = 2; end
         4'd5: begin a = int'(o[7:4]); b = int'(o[3:0]); end
         default: ;
      endcase
   endfunction

   function automatic int op_len(input logic [3:0] opc);
      case (opc)
         4'd0, 4'd3, 4'd5: return 3;
         4'd1, 4'd2, 4'd4: return 4;
         default:          return 2;
      endcase
   endfunction

   function automatic logic [15:0] rand_op();
      int r, lo;
      logic [3:0] opc;
      r  = $urandom_range(0, 9);
      lo = $urandom_range(0, 4095);
      if (r <= 6)      opc = 4'(r);
      else if (r == 7) opc = 4'd15;
      else             opc = 4'($urandom_range(7, 14));
      return {opc, lo[11:0]};
   endfunction

   task automatic fill_nop();
      for (int i = 0; i < 64; i++) imem[i] = 16'h7000;
   endtask

   task automatic do_reset();
      rst = 1'b1; run = 1'b0; halt_req = 1'b0; zero_in = 1'b0;
      @(negedge clk);
      @(negedge clk);
      rst = 1'b0;
   endtask

   // Preamble: JNZ to pc0-1, COMP there loads z from zin, then the vector op runs at pc0
   // with halt_req held so the bench can count cycles up to HALT.
   task automatic exec_vec(input vec_t v, input int idx);
      int k, nrf, ndmw, ndmr;
      bit early;
      logic [5:0] tgt;
      logic [15:0] o;
      logic [3:0] ws_c, as_c, bs_c, fn_c;
      logic [1:0] wb_c;
      ws_c = '0; as_c = '0; bs_c = '0; fn_c = '0; wb_c = '0;
      o   = v.op;
      tgt = 6'(v.pc0 - 1);
      fill_nop();
      imem[0]         = {4'h6, 6'd0, tgt};
      imem[v.pc0 - 1] = 16'h3000;
      imem[v.pc0]     = v.op;
      do_reset();
      zero_in = v.zin;
      run     = 1'b1;
      repeat (6) @(negedge clk);
      run      = 1'b0;
      halt_req = 1'b1;
      chk($sformatf("v%0d start_pc", idx), pc, v.pc0);
      k = 0; nrf = 0; ndmw = 0; ndmr = 0; early = 1'b0;
      while (!halted && k < 12) begin
         k++;
         if (k <= 2 && (rf_we || dm_we || dm_re)) early = 1'b1;
         nrf  += int'(rf_we);
         ndmw += int'(dm_we);
         ndmr += int'(dm_re);
         if (k == 2) begin
            ws_c = rf_wsel; as_c = rf_asel; bs_c = rf_bsel; wb_c = wb_sel; fn_c = alu_fn;
         end
         @(negedge clk);
      end
      chk($sformatf("v%0d cycles", idx), k, v.cyc);
      chk($sformatf("v%0d next_pc", idx), pc, v.npc);
      chk($sformatf("v%0d rf_we_count", idx), nrf, v.nrf);
      chk($sformatf("v%0d dm_we_count", idx), ndmw, v.ndmw);
      chk($sformatf("v%0d dm_re_count", idx), ndmr, v.ndmr);
      chk($sformatf("v%0d early_strobe", idx), {31'd0, early}, 0);
      chk($sformatf("v%0d alu_fn", idx), fn_c, {28'd0, o[15:12]});
      chk_opt($sformatf("v%0d wb_sel", idx), wb_c, v.wb);
      chk_opt($sformatf("v%0d rf_wsel", idx), ws_c, v.ws);
      chk_opt($sformatf("v%0d rf_asel", idx), as_c, v.as_e);
      chk_opt($sformatf("v%0d rf_bsel", idx), bs_c, v.bs);
      halt_req = 1'b0;
   endtask

   initial begin
      #2000000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1);
   end

   initial begin
      int halt_n, mode, k, mpc, len, ew, ea, eb, ewb;
      bit mz;
      logic [15:0] o;
      logic [3:0] opc;

      //       op        pc0 zin cyc npc rf dmw dmr wb  ws  as  bs
      vt[0]  = '{16'h0108, 2, 1'b0, 3, 3,  1, 0, 0, 1,  1, -1, -1};
      vt[1]  = '{16'h1345, 5, 1'b0, 4, 6,  1, 0, 0, 0,  3,  4,  5};
      vt[2]  = '{16'h2007, 9, 1'b0, 4, 10, 1, 0, 0, 0,  7,  7, -1};
      vt[3]  = '{16'h3012, 12, 1'b0, 3, 13, 0, 0, 0, -1, -1, 1, 2};
      vt[4]  = '{16'h4690, 20, 1'b0, 4, 21, 1, 0, 1, 2,  6,  9, -1};
      vt[5]  = '{16'h50AB, 30, 1'b0, 3, 31, 0, 1, 0, -1, -1, 10, 11};
      vt[6]  = '{16'h6028, 33, 1'b0, 2, 40, 0, 0, 0, -1, -1, -1, -1};
      vt[7]  = '{16'h6028, 33, 1'b1, 2, 34, 0, 0, 0, -1, -1, -1, -1};
      vt[8]  = '{16'hF000, 50, 1'b0, 2, 50, 0, 0, 0, -1, -1, -1, -1};
      vt[9]  = '{16'h9123, 44, 1'b0, 2, 45, 0, 0, 0, -1, -1, -1, -1};
      vt[10] = '{16'h0200, 63, 1'b0, 3, 0,  1, 0, 0, 1,  2, -1, -1};
      vt[11] = '{16'h603F, 17, 1'b0, 2, 63, 0, 0, 0, -1, -1, -1, -1};

      fill_nop();
      do_reset();
      chk("reset pc", pc, 0);
      chk("reset busy", busy, 0);

      for (int i = 0; i < 12; i++) exec_vec(vt[i], i);

      // Loop program: COMP sees r1==r2 on the ninth pass (cycle 80), then falls through to HALT.
      fill_nop();
      imem[0] = enc(OP_LI, R1, 4'h0, 4'h8);
      imem[1] = enc(OP_LI, R2, 4'h0, 4'h0);
      imem[2] = enc(OP_COMP, 4'h0, R1, R2);
      imem[3] = enc(OP_INC, 4'h0, 4'h0, R2);
      imem[4] = enc(OP_JNZ, 4'h0, 4'h0, 4'h2);
      imem[5] = enc(OP_HALT, 4'h0, 4'h0, 4'h0);
      do_reset();
      run = 1'b1;
      halt_n = -1;
      for (int n = 0; n < 120; n++) begin
         @(negedge clk);
         run     = 1'b0;
         zero_in = (n == 80);
         if (n == 15) chk("loop jnz_taken_pc", pc, 2);
         if (halted) begin
            halt_n = n;
            break;
         end
      end
      chk("loop halt_cycle", halt_n, 89);
      chk("loop fallthrough_pc", pc, 5);

      rst = 1'b1;
      @(negedge clk);
      rst = 1'b0;
      chk("reset2 pc", pc, 0);
      chk("reset2 ir", ir, 0);
      chk("reset2 busy", busy, 0);
      chk("reset2 halted", halted, 0);
      chk("reset2 strobes", {29'd0, rf_we, dm_we, dm_re}, 0);

      // halt_req raised in EXEC of ADD: WB still completes, then HALT, then resume.
      fill_nop();
      imem[0] = 16'h1123;
      imem[1] = 16'h0155;
      do_reset();
      run = 1'b1;
      @(negedge clk); run = 1'b0;
      @(negedge clk);
      @(negedge clk); halt_req = 1'b1;
      chk("haltadd exec alu_fn", alu_fn, 1);
      @(negedge clk);
      chk("haltadd wb rf_we", rf_we, 1);
      @(negedge clk);
      chk("haltadd halted", halted, 1);
      chk("haltadd pc", pc, 1);
      halt_req = 1'b0; run = 1'b1;
      @(negedge clk); run = 1'b0;
      chk("resume busy", busy, 1);
      chk("resume pc", pc, 1);
      @(negedge clk);
      @(negedge clk);
      chk("resume li rf_we", rf_we, 1);
      chk("resume li wb_sel", wb_sel, 1);
      chk("resume li imm", imm, 8'h55);

      // Reset during MEM of STORE drops the write.
      fill_nop();
      imem[0] = 16'h50AB;
      do_reset();
      run = 1'b1;
      @(negedge clk); run = 1'b0;
      @(negedge clk);
      @(negedge clk); rst = 1'b1;
      #1;
      chk("rststore dm_we", dm_we, 0);
      @(negedge clk); rst = 1'b0;
      chk("rststore busy", busy, 0);
      chk("rststore pc", pc, 0);
      chk("rststore ir", ir, 0);
      chk("rststore halted", halted, 0);

      // run and halt_req together from IDLE: the first instruction still executes.
      fill_nop();
      imem[0] = 16'h0108;
      do_reset();
      run = 1'b1; halt_req = 1'b1;
      @(negedge clk); run = 1'b0;
      chk("runhalt fetch busy", busy, 1);
      @(negedge clk);
      @(negedge clk);
      @(negedge clk);
      chk("runhalt halted", halted, 1);
      chk("runhalt pc", pc, 1);
      halt_req = 1'b0;

      // Randomized program and inputs against an instruction-level model.
      for (int i = 0; i < 64; i++) imem[i] = rand_op();
      do_reset();
      mode = 0; k = 1; mpc = 0; mz = 1'b0;
      for (int c = 0; c < 3000; c++) begin
         @(negedge clk);
         o   = imem[mpc];
         opc = o[15:12];
         len = op_len(opc);
         chk("rnd pc", pc, mpc);
         chk("rnd busy", busy, (mode == 1));
         chk("rnd halted", halted, (mode == 2));
         chk("rnd rf_we", rf_we, (mode == 1 && k == len &&
             (opc == 4'd0 || opc == 4'd1 || opc == 4'd2 || opc == 4'd4)));
         chk("rnd dm_re", dm_re, (mode == 1 && k == 3 && opc == 4'd4));
         chk("rnd dm_we", dm_we, (mode == 1 && k == 3 && opc == 4'd5));
         if (mode == 1 && k >= 2) begin
            exp_dec(o, ew, ea, eb, ewb);
            chk("rnd ir", ir, o);
            chk("rnd alu_fn", alu_fn, opc);
            chk("rnd imm", imm, o[7:0]);
            chk_opt("rnd rf_wsel", rf_wsel, ew);
            chk_opt("rnd rf_asel", rf_asel, ea);
            chk_opt("rnd rf_bsel", rf_bsel, eb);
            chk_opt("rnd wb_sel", wb_sel, ewb);
         end
         rst      = ($urandom_range(0, 99) == 0);
         run      = 1'($urandom_range(0, 1));
         halt_req = ($urandom_range(0, 9) == 0);
         zero_in  = 1'($urandom_range(0, 1));
         if (rst) begin
            mode = 0; mpc = 0; mz = 1'b0;
         end else if (mode == 0) begin
            if (run) begin mode = 1; k = 1; end
         end else if (mode == 2) begin
            if (run && !halt_req) begin mode = 1; k = 1; end
         end else if (k < len) begin
            k++;
         end else begin
            if (opc == 4'd3) mz = zero_in;
            if (opc == 4'd15) begin
               mode = 2;
            end else begin
               if (opc == 4'd6 && !mz) mpc = int'(o[5:0]);
               else                    mpc = (mpc + 1) % 64;
               k    = 1;
               mode = halt_req ? 2 : 1;
            end
         end
      end
      rst = 1'b0;

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
